// File: rtl/wdt_pkg.sv
// Shared types and helpers for the windowed reset watchdog.
package wdt_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    COUNT    = 2'd1,
    WARN     = 2'd2,
    FIRE     = 2'd3
  } wdt_state_e;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    TIMEOUT = 2'd1,
    EARLY   = 2'd2
  } wdt_cause_e;

  // A programmed timeout of 0 selects the largest count the counter can hold.
  function automatic logic [31:0] eff_timeout(input logic [31:0] timeout,
                                              input int unsigned width);
    logic [31:0] max_cnt;
    max_cnt = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (timeout == '0) ? max_cnt : timeout;
  endfunction

endpackage

// File: rtl/rst_pulse_gen.sv
// Fixed-width pulse generator: start launches a RST_PULSE-cycle pulse, done marks its last cycle.
module rst_pulse_gen #(
  parameter int unsigned RST_PULSE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic pulse,
  output logic done
);

  localparam int unsigned PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

  logic [PW-1:0] remain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse  <= 1'b0;
      remain <= '0;
    end else if (start) begin
      pulse  <= 1'b1;
      remain <= PW'(RST_PULSE - 1);
    end else if (pulse) begin
      if (remain == '0) pulse  <= 1'b0;
      else              remain <= remain - PW'(1);
    end
  end

  assign done = pulse && (remain == '0);

endmodule

// File: rtl/rst_window_watchdog.sv
// Windowed watchdog: fires a stretched reset on timeout or early kick; config latched and sticky once armed.
module rst_window_watchdog #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned RST_PULSE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_en,
  input  logic [CNT_W-1:0] cfg_timeout,
  input  logic [CNT_W-1:0] cfg_window,
  input  logic [CNT_W-1:0] cfg_warn,
  input  logic             kick,
  output logic             wdt_warn,
  output logic             wdt_rst,
  output logic [1:0]       wdt_cause,
  output logic             wdt_active,
  output logic [CNT_W-1:0] wdt_count,
  output logic [7:0]       fire_cnt
);

  import wdt_pkg::*;

  wdt_state_e       state, state_next;
  wdt_cause_e       cause_q, cause_next;
  logic [CNT_W-1:0] cnt_q, cnt_next;
  logic [CNT_W-1:0] tmo_q, win_q, wrn_q;
  logic [7:0]       fire_q;
  logic             warn_q, active_q;
  logic             load_cfg, start, done, pulse;

  always_comb begin
    state_next = state;
    cnt_next   = cnt_q;
    cause_next = cause_q;
    load_cfg   = 1'b0;
    unique case (state)
      DISABLED: begin
        if (cfg_en) begin
          load_cfg   = 1'b1;
          cnt_next   = '0;
          state_next = COUNT;
        end
      end
      COUNT, WARN: begin
        // Kick outranks the timeout compare, so a legal kick at count==timeout rescues.
        if (kick && (cnt_q < win_q)) begin
          state_next = FIRE;
          cnt_next   = '0;
          cause_next = EARLY;
        end else if (kick) begin
          state_next = COUNT;
          cnt_next   = '0;
        end else if (cnt_q == tmo_q) begin
          state_next = FIRE;
          cnt_next   = '0;
          cause_next = TIMEOUT;
        end else begin
          cnt_next = cnt_q + CNT_W'(1);
          if ((state == COUNT) && (cnt_next == wrn_q) && (wrn_q < tmo_q))
            state_next = WARN;
        end
      end
      FIRE: begin
        cnt_next = '0;
        if (done) state_next = COUNT;
      end
      default: state_next = DISABLED;
    endcase
  end

  assign start = (state != FIRE) && (state_next == FIRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= DISABLED;
      cause_q  <= NONE;
      cnt_q    <= '0;
      tmo_q    <= '0;
      win_q    <= '0;
      wrn_q    <= '0;
      fire_q   <= '0;
      warn_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state    <= state_next;
      cause_q  <= cause_next;
      cnt_q    <= cnt_next;
      warn_q   <= (state_next == WARN);
      active_q <= (state_next != DISABLED);
      if (load_cfg) begin
        tmo_q <= CNT_W'(eff_timeout(32'(cfg_timeout), CNT_W));
        win_q <= cfg_window;
        wrn_q <= cfg_warn;
      end
      if (start && (fire_q != 8'hFF)) fire_q <= fire_q + 8'd1;
    end
  end

  rst_pulse_gen #(.RST_PULSE(RST_PULSE)) u_pulse (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .pulse (pulse),
    .done  (done)
  );

  assign wdt_rst    = pulse;
  assign wdt_warn   = warn_q;
  assign wdt_active = active_q;
  assign wdt_cause  = cause_q;
  assign wdt_count  = cnt_q;
  assign fire_cnt   = fire_q;

endmodule

// File: tb/tb_rst_window_watchdog.sv
// Bench for rst_window_watchdog: vector table, directed corner sequences and random run against a reference model.
module tb_rst_window_watchdog;

  localparam int unsigned CNT_W     = 8;
  localparam int unsigned RST_PULSE = 4;
  localparam int          MAXC      = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, cfg_en, kick;
  logic [7:0] cfg_timeout, cfg_window, cfg_warn;
  logic       wdt_warn, wdt_rst, wdt_active;
  logic [1:0] wdt_cause;
  logic [7:0] wdt_count, fire_cnt;

  logic       b_rst_n, b_cfg_en, b_kick;
  logic [3:0] b_timeout, b_window, b_warn;
  logic       b_warn_o, b_rst_o, b_active;
  logic [1:0] b_cause;
  logic [3:0] b_count;
  logic [7:0] b_fires;

  rst_window_watchdog #(.CNT_W(CNT_W), .RST_PULSE(RST_PULSE)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_timeout(cfg_timeout),
    .cfg_window(cfg_window), .cfg_warn(cfg_warn), .kick(kick),
    .wdt_warn(wdt_warn), .wdt_rst(wdt_rst), .wdt_cause(wdt_cause),
    .wdt_active(wdt_active), .wdt_count(wdt_count), .fire_cnt(fire_cnt)
  );

  rst_window_watchdog #(.CNT_W(4), .RST_PULSE(RST_PULSE)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .cfg_en(b_cfg_en), .cfg_timeout(b_timeout),
    .cfg_window(b_window), .cfg_warn(b_warn), .kick(b_kick),
    .wdt_warn(b_warn_o), .wdt_rst(b_rst_o), .wdt_cause(b_cause),
    .wdt_active(b_active), .wdt_count(b_count), .fire_cnt(b_fires)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: armed flag, counter, remaining pulse cycles, latched thresholds.
  int m_armed, m_cnt, m_pulse, m_warn, m_cause, m_fires, m_tmo, m_win, m_wrn;

  function automatic void model_reset();
    m_armed = 0; m_cnt = 0; m_pulse = 0; m_warn = 0; m_cause = 0; m_fires = 0;
    m_tmo = 0; m_win = 0; m_wrn = 0;
  endfunction

  function automatic void m_fire(input int c);
    m_pulse = RST_PULSE;
    m_cnt   = 0;
    m_warn  = 0;
    m_cause = c;
    if (m_fires < 255) m_fires++;
  endfunction

  function automatic void model_step(input bit en, input bit kk, input int t, input int w, input int wr);
    if (m_armed == 0) begin
      if (en) begin
        m_armed = 1; m_tmo = (t == 0) ? MAXC : t; m_win = w; m_wrn = wr;
        m_cnt = 0; m_warn = 0;
      end
    end else if (m_pulse > 0) begin
      m_pulse--;
      m_cnt = 0;
    end else if (kk && m_cnt < m_win) m_fire(2);
    else if (kk) begin
      m_cnt = 0; m_warn = 0;
    end else if (m_cnt == m_tmo) m_fire(1);
    else begin
      m_cnt++;
      if (m_cnt == m_wrn && m_wrn < m_tmo) m_warn = 1;
    end
  endfunction

  task automatic check_model();
    check("model.rst",    wdt_rst,    32'(m_pulse > 0));
    check("model.warn",   wdt_warn,   32'(m_warn));
    check("model.active", wdt_active, 32'(m_armed));
    check("model.count",  wdt_count,  32'(m_cnt));
    check("model.cause",  wdt_cause,  32'(m_cause));
    check("model.fires",  fire_cnt,   32'(m_fires));
  endtask

  task automatic step(input bit chk);
    bit en, kk, rn;
    int t, w, wr;
    en = cfg_en; kk = kick; rn = rst_n;
    t = cfg_timeout; w = cfg_window; wr = cfg_warn;
    @(posedge clk);
    if (!rn) model_reset();
    else model_step(en, kk, t, w, wr);
    #1;
    if (chk) check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cfg_en = 1'b0; kick = 1'b0;
    step(1);
    step(1);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit en;
    bit kk;
    bit e_active;
    bit e_rst;
    int e_cnt;
    int e_cause;
    int e_fires;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1ms;
    $display("FAIL watchdog_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit reached;
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 0, 0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 3, 0, 0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 0, 2, 1};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 0, 2, 1};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 2, 1};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 2, 1};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 2, 1};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 2, 1};

    rst_n = 1'b0; cfg_en = 1'b0; kick = 1'b0;
    cfg_timeout = 8'd20; cfg_window = 8'd5; cfg_warn = 8'd15;
    b_rst_n = 1'b0; b_cfg_en = 1'b0; b_kick = 1'b0;
    b_timeout = 4'd0; b_window = 4'd0; b_warn = 4'd15;
    model_reset();

    // Reset values
    step(0);
    check("reset.rst", wdt_rst, 0);
    check("reset.warn", wdt_warn, 0);
    check("reset.active", wdt_active, 0);
    check("reset.count", wdt_count, 0);
    check("reset.cause", wdt_cause, 0);
    check("reset.fires", fire_cnt, 0);
    rst_n = 1'b1;
    step(1);

    // Arm, no kicks: warn at N+15, pulse N+21..N+24
    cfg_en = 1'b1;
    step(1);
    for (int k = 1; k <= 26; k++) begin
      step(1);
      if (k == 14) check("noKick.warn_pre", wdt_warn, 0);
      if (k == 15) check("noKick.warn_rise", wdt_warn, 1);
      if (k == 20) check("noKick.rst_pre", wdt_rst, 0);
      if (k >= 21 && k <= 24) check("noKick.rst_pulse", wdt_rst, 1);
      if (k == 25) begin
        check("noKick.rst_fall", wdt_rst, 0);
        check("noKick.cause", wdt_cause, 1);
        check("noKick.fires", fire_cnt, 1);
        check("noKick.count_restart", wdt_count, 0);
      end
      if (k == 26) check("noKick.count_resume", wdt_count, 1);
    end

    // Periodic kick at count 10
    for (int k = 0; k < 100; k++) begin
      kick = (m_cnt == 10);
      step(1);
      check("loop.no_warn", wdt_warn, 0);
      check("loop.no_rst", wdt_rst, 0);
      check("loop.count_bound", 32'(wdt_count <= 8'd10), 1);
    end
    kick = 1'b0;

    // Early kick at count 3, via vector table
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cfg_en = tbl[i].en;
      kick   = tbl[i].kk;
      step(1);
      check("tbl.active", wdt_active, 32'(tbl[i].e_active));
      check("tbl.rst", wdt_rst, 32'(tbl[i].e_rst));
      check("tbl.count", wdt_count, 32'(tbl[i].e_cnt));
      check("tbl.cause", wdt_cause, 32'(tbl[i].e_cause));
      check("tbl.fires", fire_cnt, 32'(tbl[i].e_fires));
    end
    kick = 1'b0;

    // Legal kick in the same cycle as count == timeout
    reached = 1'b0;
    for (int k = 0; k < 40 && !reached; k++) begin
      step(1);
      if (m_cnt == 20) reached = 1'b1;
    end
    check("kickAtTmo.reached", 32'(reached), 1);
    check("kickAtTmo.warn_before", wdt_warn, 1);
    kick = 1'b1;
    step(1);
    kick = 1'b0;
    check("kickAtTmo.count", wdt_count, 0);
    check("kickAtTmo.rst", wdt_rst, 0);
    check("kickAtTmo.warn", wdt_warn, 0);
    check("kickAtTmo.cause_held", wdt_cause, 2);
    step(1);
    check("kickAtTmo.rst_after", wdt_rst, 0);
    check("kickAtTmo.count_after", wdt_count, 1);

    // Config change and cfg_en drop after arming are ignored; reset mid-pulse
    do_reset();
    cfg_timeout = 8'd20;
    cfg_en = 1'b1;
    step(1);
    cfg_timeout = 8'd50;
    cfg_en = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      step(1);
      check("sticky.active", wdt_active, 1);
      if (k == 20) check("sticky.no_rst_yet", wdt_rst, 0);
      if (k == 21) check("sticky.rst_at_20", wdt_rst, 1);
    end
    check("midPulse.rst_before", wdt_rst, 1);
    rst_n = 1'b0;
    #1;
    check("midPulse.rst", wdt_rst, 0);
    check("midPulse.active", wdt_active, 0);
    check("midPulse.cause", wdt_cause, 0);
    check("midPulse.fires", fire_cnt, 0);
    check("midPulse.count", wdt_count, 0);
    check("midPulse.warn", wdt_warn, 0);
    model_reset();
    step(1);
    rst_n = 1'b1;

    // Randomized run against the model
    for (int k = 0; k < 3000; k++) begin
      rst_n       = ($urandom_range(0, 399) != 0);
      cfg_en      = ($urandom_range(0, 3) == 0);
      cfg_timeout = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
      cfg_window  = 8'($urandom_range(0, 30));
      cfg_warn    = 8'($urandom_range(0, 45));
      kick        = ($urandom_range(0, 11) == 0);
      step(1);
    end

    // 4-bit instance, timeout 0 selects 15; warn == timeout never warns
    rst_n = 1'b0; cfg_en = 1'b0; kick = 1'b0;
    step(0);
    check("b.reset_rst", b_rst_o, 0);
    check("b.reset_active", b_active, 0);
    check("b.reset_count", b_count, 0);
    b_rst_n = 1'b1;
    b_cfg_en = 1'b1;
    step(0);
    check("b.armed", b_active, 1);
    for (int k = 1; k <= 17; k++) begin
      step(0);
      check("b.no_warn", b_warn_o, 0);
      if (k == 15) begin
        check("b.count15", b_count, 15);
        check("b.rst_pre", b_rst_o, 0);
      end
      if (k == 16) begin
        check("b.rst_rise", b_rst_o, 1);
        check("b.cause", b_cause, 1);
        check("b.count_held", b_count, 0);
        check("b.fires", b_fires, 1);
      end
      if (k == 17) check("b.rst_hold", b_rst_o, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rst_window_watchdog.md
# rst_window_watchdog

Parametrised windowed watchdog that generates a stretched reset pulse when software either fails to kick within a timeout or kicks too early. It adds a pre-timeout warning, cause reporting and a fire counter, and sits beside the reset controller, driving one of its reset request inputs. Configuration is latched on enable, and enable is sticky until `rst_n`, so a runaway program cannot disarm the watchdog.

## Interface
- `CNT_W`, 16, width of the counter and of the timeout, window and warn thresholds
- `RST_PULSE`, 16, `wdt_rst` high time in clk cycles; must be at least 1
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low; clock clk
- `cfg_en`  in  1  arm request; the rising level is sampled while in DISABLED
- `cfg_timeout`  in  CNT_W  count at which the watchdog fires; 0 means 2^CNT_W-1
- `cfg_window`  in  CNT_W  earliest count at which a kick is legal
- `cfg_warn`  in  CNT_W  count at which the warning asserts
- `kick`  in  1  service pulse, one cycle per kick
- `wdt_warn`  out  1  pre-timeout warning
- `wdt_rst`  out  1  reset request pulse
- `wdt_cause`  out  2  cause of the last fire: 0 none, 1 timeout, 2 early kick
- `wdt_active`  out  1  high when the watchdog is armed (any state other than DISABLED)
- `wdt_count`  out  CNT_W  current counter value
- `fire_cnt`  out  8  number of fires, saturating at 255

## Operation
- States: DISABLED, COUNT, WARN, FIRE.
- **DISABLED**
  - When `cfg_en`=1, latch `cfg_timeout`, `cfg_window` and `cfg_warn`.
  - Set count=0 and go to COUNT.
- **COUNT / WARN, per cycle, in this priority order:**
  1. `kick` with count < window: early violation. Go to FIRE with cause=2.
  2. `kick` with count ≥ window: valid kick. Set count=0, go to COUNT and drop warn. A valid kick in the same cycle as count==timeout wins.
  3. count == timeout: go to FIRE with cause=1.
  4. Otherwise increment count. When count == warn and warn < timeout, go from COUNT to WARN.
- **FIRE**
  - `wdt_rst`=1 for exactly `RST_PULSE` cycles.
  - `kick` is ignored.
  - Count is held at 0.
  - After the pulse, go to COUNT with count=0.
- After arming, `cfg_en` and the `cfg_*` inputs are ignored until `rst_n`.
- Threshold edge cases:
  - window > timeout: every kick is early.
  - warn ≥ timeout: warn never asserts.
  - window = 0: every kick is legal.
- `wdt_cause` holds its value until the next fire. `fire_cnt` increments on FIRE entry.
- Asserting `rst_n` at any point, including mid-pulse, immediately returns the block to DISABLED with all outputs at their reset values.
- Reset values: `wdt_warn`=0, `wdt_rst`=0, `wdt_cause`=0, `wdt_active`=0, `wdt_count`=0, `fire_cnt`=0.

## Timing
- All outputs are registered.
- Arming: `cfg_en` sampled at edge N. From edge N, state=COUNT and count=0.
- Counting: count equals k after edge N+k.
- Timeout fire: with threshold T and no kicks, `wdt_rst` rises after edge N+T+1 and falls after edge N+T+1+`RST_PULSE`.
- Warning: `wdt_warn` rises after the edge where count transitions to W, i.e. edge N+W.
- Kick latency: a kick sampled at edge M gives count=0 after edge M, and `wdt_warn`=0 after edge M.
- Early-kick latency: a kick sampled at edge M with count < window gives `wdt_rst`=1 after edge M.

## Structure
- `wdt_pkg` contains:
  - `wdt_state_e` with DISABLED, COUNT, WARN, FIRE
  - `wdt_cause_e` with NONE=0, TIMEOUT=1, EARLY=2
  - a function that maps a timeout of 0 to the maximum count
- Sub-module `rst_pulse_gen` (parameter `RST_PULSE`): the `start` input launches a fixed-width pulse, and `done` flags its final cycle.

## Test plan
Configuration for all scenarios: CNT_W=8, RST_PULSE=4, timeout=20, window=5, warn=15.
- Arm with no kicks: warn rises after edge N+15; `wdt_rst` high for edges N+21..N+24; cause=1; `fire_cnt`=1; count restarts.
- Kick at count=10 in a loop for 100 cycles: no warn, no rst; count never exceeds 10.
- Kick at count=3: `wdt_rst` rises the next cycle; cause=2; pulse lasts 4 cycles.
- Kick at count=20 (same cycle as timeout): no fire; count=0.
- Change `cfg_timeout` to 50 and drop `cfg_en` after arming: timeout still fires at 20 and `wdt_active` stays 1.
- Assert `rst_n` in the second cycle of the pulse: `wdt_rst`=0, state=DISABLED, cause=0, `fire_cnt`=0. timeout=0 with CNT_W=4: fires at count 15.
